// File: rtl/vdiv_sequencer_if.sv
// rtl/vdiv_sequencer_if.sv - request, result and divider-side signals of the vector divide sequencer
interface vdiv_sequencer_if #(
  parameter int unsigned WIDTH = 64
);
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic [1:0]       opcode_i;
  logic [1:0]       sew_i;
  logic             in_vld_i;
  logic             in_rdy_o;
  logic             flush_i;
  logic [WIDTH-1:0] res_o;
  logic             out_vld_o;
  logic             out_rdy_i;
  logic [WIDTH-1:0] div_op_a_o;
  logic [WIDTH-1:0] div_op_b_o;
  logic [1:0]       div_opcode_o;
  logic             div_vld_o;
  logic             div_rdy_i;
  logic [WIDTH-1:0] div_res_i;
  logic             div_res_vld_i;
  logic             div_res_rdy_o;
  logic             div_flush_o;

  modport slave (
    input  op_a_i, op_b_i, opcode_i, sew_i, in_vld_i, flush_i, out_rdy_i,
    input  div_rdy_i, div_res_i, div_res_vld_i,
    output in_rdy_o, res_o, out_vld_o, div_op_a_o, div_op_b_o, div_opcode_o,
    output div_vld_o, div_res_rdy_o, div_flush_o
  );

  modport master (
    output op_a_i, op_b_i, opcode_i, sew_i, in_vld_i, flush_i, out_rdy_i,
    output div_rdy_i, div_res_i, div_res_vld_i,
    input  in_rdy_o, res_o, out_vld_o, div_op_a_o, div_op_b_o, div_opcode_o,
    input  div_vld_o, div_res_rdy_o, div_flush_o
  );
endinterface

// File: rtl/vdiv_sequencer.sv
// rtl/vdiv_sequencer.sv - splits a packed vector divide into per-element requests to a serial divider
module vdiv_sequencer #(
  parameter int unsigned WIDTH            = 64,
  parameter bit          STABLE_HANDSHAKE = 1'b1
) (
  input logic             clk_i,
  input logic             rst_ni,
  vdiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_opcode;
  logic [1:0]       r_sew;
  logic [2:0]       r_cnt;
  logic [2:0]       r_idx;

  logic             w_in_rdy;
  logic             w_div_vld;
  logic             w_div_res_rdy;
  logic             w_out_vld;
  logic             w_accept;
  logic             w_take;
  logic             w_rdy_gate;
  logic [5:0]       w_shamt;
  logic [2:0]       w_cnt_init;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [WIDTH-1:0] w_elem_mask;
  logic [WIDTH-1:0] w_res_elem;

  // Low SEW bits of v, sign- or zero-extended to the full width.
  function automatic logic [WIDTH-1:0] f_ext(input logic [WIDTH-1:0] v,
                                             input logic [1:0] sew, input logic sgn);
    logic [WIDTH-1:0] r;
    case (sew)
      2'd0:    r = {{56{sgn & v[7]}},  v[7:0]};
      2'd1:    r = {{48{sgn & v[15]}}, v[15:0]};
      2'd2:    r = {{32{sgn & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    case (r_sew)
      2'd0:    w_shamt = {r_idx, 3'b000};
      2'd1:    w_shamt = {r_idx[1:0], 4'b0000};
      2'd2:    w_shamt = {r_idx[0], 5'b00000};
      default: w_shamt = 6'd0;
    endcase
  end

  always_comb begin
    case (bus.sew_i)
      2'd0:    w_cnt_init = 3'd7;
      2'd1:    w_cnt_init = 3'd3;
      2'd2:    w_cnt_init = 3'd1;
      default: w_cnt_init = 3'd0;
    endcase
  end

  assign w_a_sh      = r_op_a >> w_shamt;
  assign w_b_sh      = r_op_b >> w_shamt;
  assign w_elem_mask = f_ext({WIDTH{1'b1}}, r_sew, 1'b0) << w_shamt;
  assign w_res_elem  = f_ext(bus.div_res_i, r_sew, 1'b0) << w_shamt;

  // Without the stability guarantee, acceptance waits out a stale divider response.
  assign w_rdy_gate = STABLE_HANDSHAKE || !bus.div_res_vld_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_in_rdy      = 1'b0;
    w_div_vld     = 1'b0;
    w_div_res_rdy = 1'b0;
    w_out_vld     = 1'b0;
    w_accept      = 1'b0;
    w_take        = 1'b0;
    if (bus.flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_in_rdy = w_rdy_gate;
          if (bus.in_vld_i && w_rdy_gate) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          w_div_vld = 1'b1;
          if (bus.div_rdy_i) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          w_div_res_rdy = 1'b1;
          if (bus.div_res_vld_i) begin
            w_take      = 1'b1;
            w_state_nxt = (r_cnt == 3'd0) ? ST_DONE : ST_ISSUE;
          end
        end
        default: begin
          w_out_vld = 1'b1;
          if (bus.out_rdy_i) w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res    <= '0;
      r_opcode <= 2'd0;
      r_sew    <= 2'd0;
      r_cnt    <= 3'd0;
      r_idx    <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.flush_i) begin
        r_cnt <= 3'd0;
        r_idx <= 3'd0;
        r_res <= '0;
      end else if (w_accept) begin
        r_op_a   <= bus.op_a_i;
        r_op_b   <= bus.op_b_i;
        r_opcode <= bus.opcode_i;
        r_sew    <= bus.sew_i;
        r_cnt    <= w_cnt_init;
        r_idx    <= 3'd0;
        r_res    <= '0;
      end else if (w_take) begin
        r_res <= (r_res & ~w_elem_mask) | w_res_elem;
        if (r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
          r_idx <= r_idx + 3'd1;
        end
      end
    end
  end

  assign bus.in_rdy_o      = w_in_rdy;
  assign bus.out_vld_o     = w_out_vld;
  assign bus.res_o         = r_res;
  assign bus.div_vld_o     = w_div_vld;
  assign bus.div_res_rdy_o = w_div_res_rdy;
  assign bus.div_op_a_o    = f_ext(w_a_sh, r_sew, r_opcode[0]);
  assign bus.div_op_b_o    = f_ext(w_b_sh, r_sew, r_opcode[0]);
  assign bus.div_opcode_o  = r_opcode;
  assign bus.div_flush_o   = bus.flush_i;

endmodule

// File: tb/tb_vdiv_sequencer.sv
// tb/tb_vdiv_sequencer.sv - directed bench for vdiv_sequencer with a latency-configurable divider responder
module tb_vdiv_sequencer;
  logic clk;
  logic rst_n;

  vdiv_sequencer_if #(.WIDTH(64)) bus ();

  vdiv_sequencer #(.WIDTH(64), .STABLE_HANDSHAKE(1'b1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Divider responder: accepts one request, answers after div_lat cycles.
  int          div_lat   = 2;
  int          hold_left = 0;
  int          lat_cnt   = 0;
  int          issues    = 0;
  bit          busy      = 1'b0;
  bit          resp_fire = 1'b0;
  logic [63:0] m_res     = '0;
  logic [63:0] rec_a[$];
  logic [63:0] rec_b[$];

  function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] op);
    logic [63:0] r;
    case (op)
      2'd0:    r = (b == 0) ? '1 : a / b;
      2'd1:    r = (b == 0) ? '1 : ((a == 64'h8000_0000_0000_0000 && b == '1) ? a
                                   : 64'($signed(a) / $signed(b)));
      2'd2:    r = (b == 0) ? a : a % b;
      default: r = (b == 0) ? a : ((a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0
                                   : 64'($signed(a) % $signed(b)));
    endcase
    return r;
  endfunction

  initial begin
    bus.div_rdy_i     = 1'b0;
    bus.div_res_vld_i = 1'b0;
    bus.div_res_i     = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n || bus.div_flush_o) begin
        busy              = 1'b0;
        resp_fire         = 1'b0;
        bus.div_res_vld_i = 1'b0;
        bus.div_rdy_i     = 1'b0;
      end else begin
        if (resp_fire) begin
          resp_fire         = 1'b0;
          busy              = 1'b0;
          bus.div_res_vld_i = 1'b0;
        end
        if (busy && !bus.div_res_vld_i) begin
          if (lat_cnt == 0) begin
            bus.div_res_vld_i = 1'b1;
            bus.div_res_i     = m_res;
          end else begin
            lat_cnt--;
          end
        end
        bus.div_rdy_i = !busy && (hold_left == 0);
        if (!busy && bus.div_vld_o && hold_left > 0) hold_left--;
        #1;
        if (bus.div_vld_o && bus.div_rdy_i) begin
          rec_a.push_back(bus.div_op_a_o);
          rec_b.push_back(bus.div_op_b_o);
          m_res   = div_model(bus.div_op_a_o, bus.div_op_b_o, bus.div_opcode_o);
          lat_cnt = div_lat;
          busy    = 1'b1;
          issues++;
        end
        if (bus.div_res_vld_i && bus.div_res_rdy_o) resp_fire = 1'b1;
      end
    end
  end

  task automatic clear_rec();
    issues = 0;
    rec_a.delete();
    rec_b.delete();
  endtask

  task automatic do_req(input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] op, input logic [1:0] sew);
    @(negedge clk);
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.opcode_i = op;
    bus.sew_i    = sew;
    bus.in_vld_i = 1'b1;
    #4 check_eq("req_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    @(negedge clk);
    bus.in_vld_i = 1'b0;
  endtask

  task automatic wait_out(input int limit, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      #4;
      cyc++;
      if (bus.out_vld_o) got = 1'b1;
    end
    check_eq("out_vld_seen", 64'(got), 64'd1);
  endtask

  task automatic release_out();
    @(negedge clk);
    bus.out_rdy_i = 1'b1;
    @(negedge clk);
    bus.out_rdy_i = 1'b0;
    #4;
    check_eq("rel_out_vld", 64'(bus.out_vld_o), 64'd0);
    check_eq("rel_in_rdy", 64'(bus.in_rdy_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    logic [63:0] hold_res;

    rst_n         = 1'b0;
    bus.op_a_i    = '0;
    bus.op_b_i    = '0;
    bus.opcode_i  = 2'd0;
    bus.sew_i     = 2'd0;
    bus.in_vld_i  = 1'b0;
    bus.flush_i   = 1'b0;
    bus.out_rdy_i = 1'b0;

    @(negedge clk);
    #4;
    check_eq("rst_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    check_eq("rst_out_vld", 64'(bus.out_vld_o), 64'd0);
    check_eq("rst_div_vld", 64'(bus.div_vld_o), 64'd0);
    check_eq("rst_div_res_rdy", 64'(bus.div_res_rdy_o), 64'd0);
    check_eq("rst_div_flush", 64'(bus.div_flush_o), 64'd0);
    check_eq("rst_res", bus.res_o, 64'd0);
    check_eq("rst_div_op_a", bus.div_op_a_o, 64'd0);
    check_eq("rst_div_op_b", bus.div_op_b_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Flush in IDLE blocks a simultaneous request.
    @(negedge clk);
    bus.in_vld_i = 1'b1;
    bus.flush_i  = 1'b1;
    #4;
    check_eq("idle_flush_in_rdy", 64'(bus.in_rdy_o), 64'd0);
    check_eq("idle_flush_div_flush", 64'(bus.div_flush_o), 64'd1);
    @(negedge clk);
    bus.in_vld_i = 1'b0;
    bus.flush_i  = 1'b0;
    #4;
    check_eq("idle_flush_no_issue", 64'(bus.div_vld_o), 64'd0);
    check_eq("idle_flush_still_idle", 64'(bus.in_rdy_o), 64'd1);

    // 64-bit signed divide, long divider latency.
    clear_rec();
    div_lat = 66;
    do_req(-64'sd100, 64'd7, 2'd1, 2'd3);
    wait_out(500, cyc);
    check_eq("s64_issues", 64'(issues), 64'd1);
    check_eq("s64_res", bus.res_o, 64'hFFFF_FFFF_FFFF_FFF2);
    check_eq("s64_lat_min", 64'(cyc >= 68), 64'd1);
    hold_res = bus.res_o;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #4;
      check_eq("s64_out_vld_hold", 64'(bus.out_vld_o), 64'd1);
      check_eq("s64_res_hold", bus.res_o, hold_res);
    end
    release_out();

    // SEW=8 unsigned divide by one: eight issues in index order.
    clear_rec();
    div_lat = 2;
    do_req(64'h0807_0605_0403_0201, 64'h0101_0101_0101_0101, 2'd0, 2'd0);
    wait_out(300, cyc);
    check_eq("e8_issues", 64'(issues), 64'd8);
    check_eq("e8_res", bus.res_o, 64'h0807_0605_0403_0201);
    if (rec_a.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check_eq("e8_op_a_order", rec_a[k], 64'(k + 1));
        check_eq("e8_op_b", rec_b[k], 64'd1);
      end
    end
    release_out();

    // SEW=16 signed remainder: sign extension, overflow and divide-by-zero pass-through.
    clear_rec();
    do_req(64'h0009_8000_0064_FFF9, 64'h0000_FFFF_0007_0002, 2'd3, 2'd1);
    wait_out(300, cyc);
    check_eq("r16_issues", 64'(issues), 64'd4);
    check_eq("r16_res", bus.res_o, 64'h0009_0000_0002_FFFF);
    if (rec_a.size() == 4) begin
      check_eq("r16_op_a_sext", rec_a[0], 64'hFFFF_FFFF_FFFF_FFF9);
      check_eq("r16_op_b_e0", rec_b[0], 64'd2);
      check_eq("r16_op_b_sext", rec_b[2], 64'hFFFF_FFFF_FFFF_FFFF);
    end
    release_out();

    // Divider stalls ISSUE for five cycles.
    clear_rec();
    hold_left = 5;
    do_req(64'd1000, 64'd10, 2'd0, 2'd3);
    for (int i = 0; i < 5; i++) begin
      #4;
      check_eq("stall_div_vld", 64'(bus.div_vld_o), 64'd1);
      check_eq("stall_op_a", bus.div_op_a_o, 64'd1000);
      check_eq("stall_op_b", bus.div_op_b_o, 64'd10);
      @(negedge clk);
    end
    wait_out(300, cyc);
    check_eq("stall_issues", 64'(issues), 64'd1);
    check_eq("stall_res", bus.res_o, 64'd100);
    release_out();

    // Flush while waiting for element 1, then a clean request.
    clear_rec();
    div_lat = 10;
    do_req({32'd50, 32'd40}, {32'd5, 32'd8}, 2'd0, 2'd2);
    cyc = 0;
    while (!(issues == 2 && bus.div_res_rdy_o) && cyc < 200) begin
      @(negedge clk);
      #4;
      cyc++;
    end
    check_eq("fl_reached_wait", 64'(issues == 2 && bus.div_res_rdy_o), 64'd1);
    @(negedge clk);
    bus.flush_i = 1'b1;
    #4;
    check_eq("fl_div_flush", 64'(bus.div_flush_o), 64'd1);
    check_eq("fl_div_vld", 64'(bus.div_vld_o), 64'd0);
    check_eq("fl_out_vld", 64'(bus.out_vld_o), 64'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #4;
    check_eq("fl_next_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #4;
      if (bus.out_vld_o) seen++;
    end
    check_eq("fl_no_out_vld", 64'(seen), 64'd0);
    clear_rec();
    do_req({-32'sd9, 32'd100}, {32'd2, -32'sd7}, 2'd1, 2'd2);
    wait_out(300, cyc);
    check_eq("fl_after_issues", 64'(issues), 64'd2);
    check_eq("fl_after_res", bus.res_o, 64'hFFFF_FFFC_FFFF_FFF2);
    release_out();

    // Reset asserted while DONE is waiting on out_rdy.
    clear_rec();
    div_lat = 2;
    do_req(64'd17, 64'd5, 2'd2, 2'd3);
    wait_out(300, cyc);
    check_eq("rd_res", bus.res_o, 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rd_out_vld_async", 64'(bus.out_vld_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check_eq("rd_in_rdy", 64'(bus.in_rdy_o), 64'd1);
    check_eq("rd_res_clr", bus.res_o, 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      if (bus.out_vld_o || bus.div_vld_o) seen++;
    end
    check_eq("rd_no_handshake", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vdiv_sequencer.md
VDIV_SEQUENCER -- requirements
Module: vdiv_sequencer

Interface
REQ-001 Parameter: WIDTH, 64, packed operand/result width in bits; only 64 is supported.
REQ-002 Parameter: STABLE_HANDSHAKE, 1, in_rdy_o does not drop while in_vld_i is held.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous and active-low.
REQ-005 op_a_i / op_b_i  input  WIDTH each  packed dividend / divisor elements; element k occupies bits [k*SEW+SEW-1 : k*SEW].
REQ-006 opcode_i  input  2  0 udiv, 1 div, 2 urem, 3 rem.
REQ-007 sew_i  input  2  element width: 0=8, 1=16, 2=32, 3=64 bits.
REQ-008 in_vld_i / in_rdy_o  input / output  1 each  upstream request handshake.
REQ-009 flush_i  input  1  abort the current operation.
REQ-010 res_o  output  WIDTH  packed result.
REQ-011 out_vld_o / out_rdy_i  output / input  1 each  result handshake.
REQ-012 div_op_a_o / div_op_b_o  output  WIDTH each  element operands sent to the serial divider.
REQ-013 div_opcode_o  output  2  opcode sent to the divider.
REQ-014 div_vld_o / div_rdy_i  output / input  1 each  divider issue handshake.
REQ-015 div_res_i  input  WIDTH  divider result.
REQ-016 div_res_vld_i / div_res_rdy_o  input / output  1 each  divider result handshake.
REQ-017 div_flush_o  output  1  flush forwarded to the divider.

Function
REQ-018 The state machine SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-019 A handshake SHALL complete only in a cycle where vld and rdy are both high.
REQ-020 IDLE SHALL drive in_rdy_o=1.
- On in_vld_i: capture op_a_i, op_b_i, opcode_i and sew_i.
- Load the element counter with N-1, where N = 64/SEW (8, 4, 2 or 1).
- Clear the result register and the element index, then go to ISSUE.
REQ-021 in_rdy_o SHALL be 0 in every state other than IDLE.
REQ-022 ISSUE SHALL drive div_vld_o=1 with the element at the current index.
- Signed opcodes (opcode[0]=1): operands sign-extended to WIDTH.
- Unsigned opcodes: operands zero-extended.
- div_opcode_o equals the captured opcode.
- On div_rdy_i: go to WAIT.
REQ-023 Operands and div_vld_o SHALL stay stable in ISSUE until accepted.
REQ-024 Exactly one divider request SHALL be outstanding at any time.
REQ-025 WAIT SHALL drive div_res_rdy_o=1; div_res_rdy_o SHALL be 0 in every other state.
REQ-026 When div_res_vld_i is seen in WAIT:
- Write div_res_i[SEW-1:0] into result bits of the current index.
- If the counter is 0: go to DONE.
- Otherwise: decrement the counter, increment the index, return to ISSUE.
REQ-027 DONE SHALL drive out_vld_o=1 with res_o equal to the packed result.
- res_o stays stable until out_rdy_i.
- On out_rdy_i: go to IDLE.
REQ-028 Result bits above N*SEW SHALL NOT occur; all 64 bits are covered for every SEW.
REQ-029 Divide-by-zero and signed-overflow values SHALL be passed through from the divider unmodified.
REQ-030 Each element SHALL be truncated to SEW bits after the divider returns it.
REQ-031 Minimum latency from input acceptance to out_vld_o SHALL be N*(2 + divider latency) cycles.
REQ-032 flush_i SHALL take priority in every state.
- div_flush_o = flush_i, combinationally.
- Next state is IDLE.
- div_vld_o, out_vld_o and in_rdy_o are forced to 0 in that cycle.
- The counter and index are cleared.
- A divider response arriving in the cycle after the flush is ignored.
REQ-033 A flush in IDLE SHALL leave the module idle; a request presented in the same cycle SHALL NOT be accepted.

Reset
REQ-034 While rst_ni=0, the module SHALL be in IDLE with all registers cleared.
- Outputs: in_rdy_o=1; out_vld_o, div_vld_o, div_res_rdy_o and div_flush_o = 0.
- res_o and the div operand outputs = 0.
REQ-035 Reset asserted mid-operation SHALL discard all state; no output handshake SHALL follow its release.

Verification
REQ-036 sew=3, opcode=1, a=-100, b=7, divider model latency 66 -> one issue; res_o=0xFFFF_FFFF_FFFF_FFF2 (-14); out_vld_o held until out_rdy_i.
REQ-037 sew=0, opcode=0, a=0x0807060504030201 repeated by element, b=0x0101010101010101 -> eight issues with index order 0..7; res_o=a.
REQ-038 sew=1, opcode=3, element0 a=0xFFF9 (-7), b=0x0002 -> div_op_a_o=0xFFFF_FFFF_FFFF_FFF9; result element0=0xFFFF (-1).
REQ-039 div_rdy_i held low 5 cycles in ISSUE -> div_vld_o and operands stable for all 5 cycles; exactly one request issued.
REQ-040 flush_i pulsed in WAIT with sew=2 after element 0 returned -> div_flush_o=1 that cycle; next cycle in_rdy_o=1; no out_vld_o; a new request then completes correctly.
REQ-041 rst_ni dropped in DONE with out_rdy_i=0 -> out_vld_o=0 immediately; after release in_rdy_o=1 and res_o=0.
